// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse-pointer sprite controller.
// Sprite is 32x32 pixels, 2-bit palette codes, 4:4:4 colour.
package mouse_pkg;
  localparam int SPRITE_BITS = 5;
  localparam int DATA_WIDTH  = 2;
  localparam int COORD_WIDTH = 11;
  localparam int COLOR_WIDTH = 12;
  localparam int ADDR_WIDTH  = 2 * SPRITE_BITS;

  typedef logic [ADDR_WIDTH-1:0]  sprite_addr_t;
  typedef logic [DATA_WIDTH-1:0]  sprite_pix_t;
  typedef logic [COLOR_WIDTH-1:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    COMMIT
  } wr_state_t;
endpackage

// File: rtl/mouse_sprite_palette.sv
// Sprite palette lookup: 2-bit pixel code to 12-bit colour.
// Code 0 is transparent and maps to black.
module mouse_sprite_palette
  import mouse_pkg::*;
#(
  parameter rgb_t PAL1 = 12'h000,
  parameter rgb_t PAL2 = 12'hFFF,
  parameter rgb_t PAL3 = 12'h888
) (
  input  sprite_pix_t i_code,
  output rgb_t        o_rgb
);

  // Four-entry colour table
  always_comb begin
    o_rgb = '0;
    unique case (i_code)
      2'd1:    o_rgb = PAL1;
      2'd2:    o_rgb = PAL2;
      2'd3:    o_rgb = PAL3;
      default: o_rgb = '0;
    endcase
  end

endmodule

// File: rtl/mouse_sprite_ctrl.sv
// Mouse sprite controller: render read path, palette output and
// a vblank-deferred single-entry host write scheduler.
module mouse_sprite_ctrl
  import mouse_pkg::*;
#(
  parameter rgb_t PAL1 = 12'h000,
  parameter rgb_t PAL2 = 12'hFFF,
  parameter rgb_t PAL3 = 12'h888
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  logic                   frame_start,
  input  logic                   vblank,
  input  logic [COORD_WIDTH-1:0] pos_x,
  input  logic [COORD_WIDTH-1:0] pos_y,
  input  logic                   wr_valid,
  input  sprite_addr_t           wr_addr,
  input  sprite_pix_t            wr_data,
  output logic                   wr_ready,
  output logic                   ram_we,
  output sprite_addr_t           ram_addr_w,
  output sprite_pix_t            ram_din,
  output sprite_addr_t           ram_addr_r,
  input  sprite_pix_t            ram_dout,
  output rgb_t                   rgb_out,
  output logic                   rgb_en
);

  logic [COORD_WIDTH-1:0] r_lx;
  logic [COORD_WIDTH-1:0] r_ly;
  logic [COORD_WIDTH:0]   w_dx;
  logic [COORD_WIDTH:0]   w_dy;
  logic                   w_hit;
  logic                   r_hit_d1;
  logic                   r_hit_d2;
  sprite_addr_t           r_raddr;
  rgb_t                   w_pal;

  wr_state_t              r_state;
  logic                   r_wr_ready;
  logic                   r_ram_we;
  sprite_addr_t           r_waddr;
  sprite_pix_t            r_wdata;

  // One extra bit keeps the subtraction from wrapping
  assign w_dx = {1'b0, x} - {1'b0, r_lx};
  assign w_dy = {1'b0, y} - {1'b0, r_ly};

  // Offset below the sprite side means all upper bits are zero
  assign w_hit = (x >= r_lx)
              && (w_dx[COORD_WIDTH:SPRITE_BITS] == '0)
              && (y >= r_ly)
              && (w_dy[COORD_WIDTH:SPRITE_BITS] == '0)
              && !vblank;

  // Pointer position only moves at frame boundaries
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lx <= '0;
      r_ly <= '0;
    end else if (frame_start) begin
      r_lx <= pos_x;
      r_ly <= pos_y;
    end
  end

  // Stage 1: hit flag and RAM read address
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_raddr  <= '0;
      r_hit_d1 <= 1'b0;
    end else begin
      r_raddr  <= {w_dy[SPRITE_BITS-1:0], w_dx[SPRITE_BITS-1:0]};
      r_hit_d1 <= w_hit;
    end
  end

  // Stage 2: align hit with the registered RAM data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hit_d2 <= 1'b0;
    end else begin
      r_hit_d2 <= r_hit_d1;
    end
  end

  mouse_sprite_palette #(
    .PAL1 (PAL1),
    .PAL2 (PAL2),
    .PAL3 (PAL3)
  ) u_pal (
    .i_code (ram_dout),
    .o_rgb  (w_pal)
  );

  // Write scheduler: hold one host write until vblank
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wr_ready <= 1'b0;
      r_ram_we   <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_ram_we <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_wr_ready <= 1'b1;
          if (wr_valid && r_wr_ready) begin
            r_waddr    <= wr_addr;
            r_wdata    <= wr_data;
            r_wr_ready <= 1'b0;
            r_state    <= PEND;
          end
        end
        PEND: begin
          if (vblank) begin
            r_ram_we <= 1'b1;
            r_state  <= COMMIT;
          end
        end
        COMMIT: begin
          r_wr_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_addr_r = r_raddr;
  assign rgb_en     = r_hit_d2 && (ram_dout != '0);
  assign rgb_out    = rgb_en ? w_pal : '0;
  assign wr_ready   = r_wr_ready;
  assign ram_we     = r_ram_we;
  assign ram_addr_w = r_waddr;
  assign ram_din    = r_wdata;

endmodule

// File: doc/mouse_sprite_ctrl.md
Name: mouse_sprite_ctrl

Overview:
Sequences the 32x32, 2-bit-per-pixel mouse-pointer sprite RAM for the video pipeline.
- Renders: from the current pixel coordinate and the latched pointer position, computes the sprite-hit flag and the RAM read address. Maps the returned 2-bit code through a 4-entry palette to a 12-bit colour plus an overlay enable.
- Owns the RAM write port: buffers one host bitmap write and commits it only during vertical blanking, so no frame ever shows a partial update.
- Sits between the VGA sync/pixel generator, the host bus, and the sprite RAM.

Parameters:
SPRITE_BITS, 5, log2 of sprite side (32 px); RAM address width = 2*SPRITE_BITS
DATA_WIDTH, 2, bits per sprite pixel (palette index)
COORD_WIDTH, 11, width of pixel and pointer coordinates
COLOR_WIDTH, 12, output colour width (4:4:4)
PAL1, 12'h000, colour for code 1
PAL2, 12'hFFF, colour for code 2
PAL3, 12'h888, colour for code 3 (code 0 is always transparent)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
x  in  COORD_WIDTH  current pixel column
y  in  COORD_WIDTH  current pixel row
frame_start  in  1  one-cycle pulse at start of each frame
vblank  in  1  high during vertical blanking
pos_x  in  COORD_WIDTH  requested pointer left edge
pos_y  in  COORD_WIDTH  requested pointer top edge
wr_valid  in  1  host write request
wr_addr  in  2*SPRITE_BITS  host sprite pixel address {row,col}
wr_data  in  DATA_WIDTH  host pixel code
wr_ready  out  1  controller can accept a host write
ram_we  out  1  RAM write enable
ram_addr_w  out  2*SPRITE_BITS  RAM write address
ram_din  out  DATA_WIDTH  RAM write data
ram_addr_r  out  2*SPRITE_BITS  RAM read address
ram_dout  in  DATA_WIDTH  RAM read data (registered; valid 1 cycle after ram_addr_r)
rgb_out  out  COLOR_WIDTH  sprite colour
rgb_en  out  1  sprite pixel opaque, overlay rgb_out

Behaviour:
Clock and reset
- Single clock `clk`. Reset is synchronous and active-low on `reset_n`; all state is sampled on posedge clk.
- Values while reset_n=0: ram_we=0, wr_ready=0, rgb_en=0, rgb_out=0, ram_addr_r=0, ram_addr_w=0, ram_din=0, latched position=(0,0), pending write cleared.
- First cycle after release: wr_ready=1.
- Reset asserted mid-operation drops any pending write; no ram_we is issued.

Position latch
- lx, ly load pos_x, pos_y on cycles with frame_start=1. Otherwise they hold.
- Pointer never moves mid-frame.

Hit and address (stage 1, registered)
- dx = x - lx and dy = y - ly, computed at COORD_WIDTH+1 bits, unsigned, no wrap.
- hit = (x >= lx) && (dx < 2**SPRITE_BITS) && (y >= ly) && (dy < 2**SPRITE_BITS) && !vblank.
- A pointer partially off the right or bottom edge is clipped, never wrapped.
- ram_addr_r <= {dy[SPRITE_BITS-1:0], dx[SPRITE_BITS-1:0]}.
- hit_d1 <= hit.

Colour (stage 2, registered)
- hit_d2 <= hit_d1.
- rgb_en = hit_d2 && (ram_dout != 0).
- rgb_out = palette[ram_dout] when rgb_en, else 0.
- Total latency from x/y to rgb_out/rgb_en is exactly 2 cycles; the pixel pipeline delays its background by 2 to match.

Write scheduler (FSM: IDLE, PEND, COMMIT)
- IDLE: wr_ready=1. wr_valid=1 captures wr_addr and wr_data into a holding register and moves to PEND. The transfer completes on wr_valid && wr_ready.
- PEND: wr_ready=0. When vblank=1, move to COMMIT.
- COMMIT: ram_we=1 for exactly one cycle with the held address and data, wr_ready=0, then return to IDLE.
- ram_we is never asserted outside COMMIT, and never while vblank was 0 on the preceding cycle.
- A write captured while vblank is already high commits 2 cycles after acceptance.
- If vblank falls in the same cycle the FSM enters COMMIT, the commit still completes. Rendering reads are off during vblank, so no read/write collision reaches the display.
- frame_start coincident with any FSM state has no effect on the FSM.
- Maximum throughput: one write per 3 cycles during vblank.

Decomposition:
- Shared package mouse_pkg:
  - SPRITE_BITS and DATA_WIDTH constants
  - typedef sprite_addr_t (logic [2*SPRITE_BITS-1:0])
  - typedef sprite_pix_t
  - typedef rgb_t
  - enum wr_state_t {IDLE, PEND, COMMIT}
- One natural sub-module, mouse_sprite_palette: a combinational 2-bit to 12-bit lookup.
- The sprite RAM is instantiated alongside this block, not inside it.

Test Plan:
- Reset release: hold reset_n=0 for 3 cycles with wr_valid=1 -> ram_we=0, rgb_en=0, wr_ready=0 throughout; wr_ready=1 on the first cycle after reset_n=1.
- Position latch: pos=(100,50) plus frame_start, then pos changes to (300,300) mid-frame -> at x=100, y=50, ram_addr_r=0 one cycle later; at x=131, y=81, ram_addr_r=10'h3FF; at x=132 no hit; no hit at (300,300) until the next frame_start.
- Latency and palette: preload RAM[0]=2 and RAM[1]=0, pixel (100,50) then (101,50) -> 2 cycles later rgb_en=1, rgb_out=12'hFFF; then rgb_en=0, rgb_out=0.
- Edge clipping: pos=(630,470), x in 630..639 and x=0..21 on the same row -> hits only for x>=630, none at x<30 (no wrap).
- Deferred write: wr_valid with addr 10'h021, data 3 while vblank=0 -> accepted, wr_ready=0, no ram_we; after vblank rises, exactly one ram_we pulse with addr 10'h021, data 3; wr_ready returns to 1 next cycle.
- Reset mid-operation: write pending in PEND, assert reset_n=0 before vblank -> no ram_we ever issued for it; FSM in IDLE after release.
